// File: rtl/lbs_bridge.sv
// Bridge from an asynchronous host bus onto the CIB and per-channel CAN register ports.
// Host strobes are resynchronised, the page is decoded once per access and a single
// we/re pulse is issued; read data is held on lbs_dio until the host releases cs_n.
module lbs_bridge #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CH_NUMS = 4,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      lbs_addr,
    inout  wire  [DATA_W-1:0]      lbs_dio,
    input  logic                   lbs_cs_n,
    input  logic                   lbs_rw_n,
    input  logic                   lbs_oe_n,
    output logic                   lbs_rdy_n,
    output logic [7:0]             cib_addr,
    output logic [DATA_W-1:0]      cib_din,
    input  logic [DATA_W-1:0]      cib_dout,
    output logic                   cib_we,
    output logic                   cib_re,
    output logic                   cib_cs_n,
    output logic [7:0]             can_addr,
    output logic [7:0]             can_din,
    input  logic [8*CH_NUMS-1:0]   can_dout,
    output logic                   can_we,
    output logic                   can_re,
    output logic [CH_NUMS-1:0]     can_cs_n,
    output logic [7:0]             err_cnt,
    input  logic                   err_clr
);

    localparam int unsigned PAGE_W = ADDR_W - 8;

    typedef enum logic [2:0] {StIdle, StWrite, StRdWait, StRdHold, StRelease} state_e;

    state_e              state_q, state_d;
    logic [1:0]          cs_sync_q, rw_sync_q, oe_sync_q;
    logic [ADDR_W-1:0]   addr_s1_q, addr_s2_q;
    logic [DATA_W-1:0]   din_s1_q, din_s2_q;
    logic                cs_s, rw_s, oe_s;
    logic [PAGE_W-1:0]   page;
    logic                hit_cib;
    logic [CH_NUMS-1:0]  hit_can;
    logic [7:0]          addr_q;
    logic [DATA_W-1:0]   din_q;
    logic                tgt_cib_q;
    logic [CH_NUMS-1:0]  tgt_can_q;
    logic [3:0]          cnt_q;
    logic [DATA_W-1:0]   rd_data_q, rd_sel;
    logic [7:0]          err_q;
    logic                start, capture, sel, rd_first, dio_oe;

    assign cs_s = cs_sync_q[1];
    assign rw_s = rw_sync_q[1];
    assign oe_s = oe_sync_q[1];
    assign page = addr_s2_q[ADDR_W-1:8];

    // Two-stage resynchronisation of all host inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q <= 2'b11;
            rw_sync_q <= 2'b11;
            oe_sync_q <= 2'b11;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            din_s1_q  <= '0;
            din_s2_q  <= '0;
        end else begin
            cs_sync_q <= {cs_sync_q[0], lbs_cs_n};
            rw_sync_q <= {rw_sync_q[0], lbs_rw_n};
            oe_sync_q <= {oe_sync_q[0], lbs_oe_n};
            addr_s1_q <= lbs_addr;
            addr_s2_q <= addr_s1_q;
            din_s1_q  <= lbs_dio;
            din_s2_q  <= din_s1_q;
        end
    end

    // Page decode of the synchronised address
    always_comb begin
        hit_cib = (page == '0);
        hit_can = '0;
        for (int unsigned i = 0; i < CH_NUMS; i++) begin
            hit_can[i] = (page == PAGE_W'(8 + i));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a released cs_n aborts any state back to idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!cs_s && !rw_s) begin
                    state_d = StWrite;
                end else if (!cs_s && !oe_s && rw_s) begin
                    state_d = StRdWait;
                end
            end
            StWrite:  state_d = cs_s ? StIdle : StRelease;
            StRdWait: begin
                if (cs_s) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'(RD_LAT - 1)) begin
                    state_d = StRdHold;
                end
            end
            StRdHold, StRelease: begin
                if (cs_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; strobes and selects only for a mapped target
    always_comb begin
        sel       = (state_q == StWrite) || (state_q == StRdWait);
        rd_first  = (state_q == StRdWait) && (cnt_q == 4'd0);
        cib_we    = (state_q == StWrite) && tgt_cib_q;
        can_we    = (state_q == StWrite) && (|tgt_can_q);
        cib_re    = rd_first && tgt_cib_q;
        can_re    = rd_first && (|tgt_can_q);
        cib_cs_n  = !(sel && tgt_cib_q);
        can_cs_n  = ~({CH_NUMS{sel}} & tgt_can_q);
        lbs_rdy_n = !((state_q == StRdHold) || (state_q == StRelease));
        dio_oe    = (state_q == StRdHold) && !lbs_cs_n && !lbs_oe_n;
    end

    assign start   = (state_q == StIdle) && ((state_d == StWrite) || (state_d == StRdWait));
    assign capture = (state_q == StRdWait) && (state_d == StRdHold);

    // Read-data mux; CAN bytes are zero-extended, unmapped reads return zero
    always_comb begin
        rd_sel = '0;
        if (tgt_cib_q) begin
            rd_sel = cib_dout;
        end
        for (int unsigned i = 0; i < CH_NUMS; i++) begin
            if (tgt_can_q[i]) begin
                rd_sel = DATA_W'(can_dout[8*i +: 8]);
            end
        end
    end

    // Per-access address/data/target latch, read latency counter and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            din_q     <= '0;
            tgt_cib_q <= 1'b0;
            tgt_can_q <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (start) begin
                addr_q    <= addr_s2_q[7:0];
                din_q     <= din_s2_q;
                tgt_cib_q <= hit_cib;
                tgt_can_q <= hit_can;
            end
            cnt_q <= (state_q == StRdWait) ? cnt_q + 4'd1 : 4'd0;
            if (capture) begin
                rd_data_q <= rd_sel;
            end
        end
    end

    // Saturating unmapped-access counter; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (start && !hit_cib && !(|hit_can) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign cib_addr = addr_q;
    assign can_addr = addr_q;
    assign cib_din  = din_q;
    assign can_din  = din_q[7:0];
    assign err_cnt  = err_q;
    assign lbs_dio  = dio_oe ? rd_data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_lbs_bridge.sv
// Scoreboard bench for lbs_bridge: host accesses push expected bus events, a monitor
// pops and compares each strobe and each ready assertion as the DUT presents it.
module tb_lbs_bridge;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int CH_NUMS = 4;
    localparam int RD_LAT  = 2;

    localparam int K_CIB_WE = 1;
    localparam int K_CAN_WE = 2;
    localparam int K_CIB_RE = 3;
    localparam int K_CAN_RE = 4;
    localparam int K_RDY    = 5;
    localparam int T_CIB    = 100;
    localparam int T_NONE   = -1;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        cib_cs_n;
        logic [3:0]  can_cs_n;
        int          cyc;
        bit          chk_data;
    } ev_t;

    logic              clk;
    logic              rst_n;
    logic [11:0]       lbs_addr;
    wire  [15:0]       lbs_dio;
    logic              lbs_cs_n, lbs_rw_n, lbs_oe_n;
    logic              lbs_rdy_n;
    logic [7:0]        cib_addr;
    logic [15:0]       cib_din, cib_dout;
    logic              cib_we, cib_re, cib_cs_n;
    logic [7:0]        can_addr, can_din;
    logic [31:0]       can_dout;
    logic              can_we, can_re;
    logic [3:0]        can_cs_n;
    logic [7:0]        err_cnt;
    logic              err_clr;

    logic              drv_en;
    logic [15:0]       drv_data;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                model_err = 0;
    ev_t               exp_q[$];

    assign lbs_dio = drv_en ? drv_data : 16'hzzzz;

    lbs_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CH_NUMS(CH_NUMS),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lbs_addr (lbs_addr),
        .lbs_dio  (lbs_dio),
        .lbs_cs_n (lbs_cs_n),
        .lbs_rw_n (lbs_rw_n),
        .lbs_oe_n (lbs_oe_n),
        .lbs_rdy_n(lbs_rdy_n),
        .cib_addr (cib_addr),
        .cib_din  (cib_din),
        .cib_dout (cib_dout),
        .cib_we   (cib_we),
        .cib_re   (cib_re),
        .cib_cs_n (cib_cs_n),
        .can_addr (can_addr),
        .can_din  (can_din),
        .can_dout (can_dout),
        .can_we   (can_we),
        .can_re   (can_re),
        .can_cs_n (can_cs_n),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode: CIB on page 0, CAN channel i on page 8+i, anything else unmapped
    function automatic int target(input logic [11:0] a);
        int page;
        page = int'(a[11:8]);
        if (page == 0) return T_CIB;
        if (page >= 8 && page < 8 + CH_NUMS) return page - 8;
        return T_NONE;
    endfunction

    function automatic logic [15:0] read_model(input int t);
        if (t == T_CIB) return cib_dout;
        if (t == T_NONE) return 16'h0000;
        return 16'((can_dout >> (8 * t)) & 32'hFF);
    endfunction

    // One host access; optional err_clr at FSM entry, 1-clock cs_n abort, or reset in hold
    task automatic host_access(input bit wr, input logic [11:0] addr, input logic [15:0] data,
                               input int hold, input bit clr, input bit abort, input bit rst_mid);
        int         t;
        int         c0;
        int         waited;
        ev_t        e;
        logic [3:0] one_hot;
        t = target(addr);
        @(negedge clk);
        c0       = cyc;
        lbs_addr = addr;
        drv_data = data;
        drv_en   = wr;
        lbs_rw_n = !wr;
        lbs_oe_n = wr;
        lbs_cs_n = 1'b0;
        if (t != T_NONE) begin
            one_hot    = (t == T_CIB) ? 4'b0000 : (4'b0001 << t);
            e.kind     = wr ? ((t == T_CIB) ? K_CIB_WE : K_CAN_WE)
                            : ((t == T_CIB) ? K_CIB_RE : K_CAN_RE);
            e.addr     = addr[7:0];
            e.data     = !wr ? 16'h0000 : ((t == T_CIB) ? data : {8'h00, data[7:0]});
            e.cib_cs_n = (t != T_CIB);
            e.can_cs_n = ~one_hot;
            e.cyc      = c0 + 3;
            e.chk_data = 1'b1;
            exp_q.push_back(e);
        end
        if (!abort) begin
            e.kind     = K_RDY;
            e.addr     = 8'h00;
            e.data     = wr ? 16'h0000 : read_model(t);
            e.cib_cs_n = 1'b1;
            e.can_cs_n = 4'hF;
            e.cyc      = c0 + (wr ? 4 : 3 + RD_LAT);
            e.chk_data = !wr;
            exp_q.push_back(e);
        end
        if (t == T_NONE && model_err < 255) model_err++;
        if (clr) begin
            model_err = 0;
            repeat (2) @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        if (abort) begin
            @(negedge clk);
            lbs_cs_n = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            waited = 0;
            while (lbs_rdy_n && waited < 30) begin
                @(negedge clk);
                waited++;
            end
            chk("rdy_asserted", {31'd0, lbs_rdy_n}, 32'd0);
            repeat (hold + 1) @(negedge clk);
            if (rst_mid) begin
                rst_n = 1'b0;
                #1;
                model_err = 0;
                chk("rst_rdy_n", {31'd0, lbs_rdy_n}, 32'd1);
                chk("rst_cs_n", {27'd0, cib_cs_n, can_cs_n}, 32'h1F);
                chk("rst_strobes", {28'd0, cib_we, cib_re, can_we, can_re}, 32'd0);
                chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
                chk("rst_cib_regs", {8'd0, cib_addr, cib_din}, 32'd0);
                chk("rst_can_regs", {16'd0, can_addr, can_din}, 32'd0);
            end
        end
        lbs_cs_n = 1'b1;
        lbs_oe_n = 1'b1;
        lbs_rw_n = 1'b1;
        drv_en   = 1'b0;
        if (rst_mid) begin
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (4) @(negedge clk);
        chk("rdy_released", {31'd0, lbs_rdy_n}, 32'd1);
        chk("err_cnt", {24'd0, err_cnt}, 32'(model_err));
    endtask

    // Monitor: every strobe cycle and every falling edge of lbs_rdy_n is one DUT event
    initial begin
        logic prev_rdy;
        bit   have;
        bit   ok;
        ev_t  a;
        ev_t  e;
        prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            have       = 1'b0;
            a.kind     = 0;
            a.addr     = 8'h00;
            a.data     = 16'h0000;
            a.cib_cs_n = 1'b1;
            a.can_cs_n = 4'hF;
            a.cyc      = cyc;
            a.chk_data = 1'b1;
            if (cib_we || can_we || cib_re || can_re) begin
                have       = 1'b1;
                a.kind     = cib_we ? K_CIB_WE : can_we ? K_CAN_WE : cib_re ? K_CIB_RE : K_CAN_RE;
                a.addr     = cib_we || cib_re ? cib_addr : can_addr;
                a.data     = cib_we ? cib_din : can_we ? {8'h00, can_din} : 16'h0000;
                a.cib_cs_n = cib_cs_n;
                a.can_cs_n = can_cs_n;
            end else if (prev_rdy && !lbs_rdy_n) begin
                have   = 1'b1;
                a.kind = K_RDY;
                a.data = lbs_dio;
            end
            prev_rdy = lbs_rdy_n;
            if (have) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h at cycle %0d, required no event",
                             a.kind, a.addr, a.data, a.cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (a.kind == e.kind) && (a.cyc == e.cyc) && (a.addr == e.addr) &&
                         (a.cib_cs_n == e.cib_cs_n) && (a.can_cs_n == e.can_cs_n) &&
                         (!e.chk_data || a.data == e.data);
                    if (ok) begin
                        n_pass++;
                    end else begin
                        $display("FAIL bus_event: got kind=%0d addr=%h data=%h cib_cs_n=%b can_cs_n=%b cyc=%0d, required kind=%0d addr=%h data=%h cib_cs_n=%b can_cs_n=%b cyc=%0d",
                                 a.kind, a.addr, a.data, a.cib_cs_n, a.can_cs_n, a.cyc,
                                 e.kind, e.addr, e.data, e.cib_cs_n, e.can_cs_n, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic [11:0] a;
        logic [3:0]  pg;
        int          r;
        rst_n    = 1'b0;
        lbs_addr = '0;
        lbs_cs_n = 1'b1;
        lbs_rw_n = 1'b1;
        lbs_oe_n = 1'b1;
        drv_en   = 1'b0;
        drv_data = '0;
        err_clr  = 1'b0;
        cib_dout = 16'h1234;
        can_dout = 32'h0;
        #1;
        chk("reset_rdy_n", {31'd0, lbs_rdy_n}, 32'd1);
        chk("reset_cs_n", {27'd0, cib_cs_n, can_cs_n}, 32'h1F);
        chk("reset_strobes", {28'd0, cib_we, cib_re, can_we, can_re}, 32'd0);
        chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("reset_regs", {cib_addr, can_addr, can_din, 8'd0}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: CIB write, CAN channel 1 read, unmapped write
        host_access(1'b1, 12'h012, 16'hA5C3, 3, 1'b0, 1'b0, 1'b0);
        can_dout = {8'h11, 8'h22, 8'h7E, 8'h33};
        host_access(1'b0, 12'h905, 16'h0000, 2, 1'b0, 1'b0, 1'b0);
        host_access(1'b1, 12'h312, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0);

        // Saturation of the unmapped counter, then clear coincident with an access
        for (int n = 0; n < 300; n++) begin
            host_access(n[0], 12'h3A0 + 12'(n % 16), 16'(n), 0, 1'b0, 1'b0, 1'b0);
        end
        host_access(1'b1, 12'h7FF, 16'h0001, 0, 1'b1, 1'b0, 1'b0);

        // Aborts after one cycle in WRITE / RD_WAIT
        host_access(1'b0, 12'h0C4, 16'h0000, 0, 1'b0, 1'b1, 1'b0);
        host_access(1'b1, 12'hA21, 16'h4455, 0, 1'b0, 1'b1, 1'b0);

        // Long cs_n hold on a write
        host_access(1'b1, 12'h0EE, 16'h6789, 50, 1'b0, 1'b0, 1'b0);

        // Randomised accesses across all pages
        for (int n = 0; n < 60; n++) begin
            cib_dout = 16'($urandom);
            can_dout = $urandom;
            r = $urandom_range(0, 5);
            if (r == 0) begin
                pg = 4'd0;
            end else if (r <= 4) begin
                pg = 4'(7 + r);
            end else begin
                r  = $urandom_range(1, 10);
                pg = (r > 7) ? 4'(r + 4) : 4'(r);
            end
            a = {pg, 8'($urandom)};
            host_access(1'($urandom), a, 16'($urandom), $urandom_range(0, 4), 1'b0, 1'b0, 1'b0);
        end

        // Reset while holding read data, then a normal read
        host_access(1'b0, 12'h3FF, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        cib_dout = 16'hC0DE;
        host_access(1'b0, 12'h040, 16'h0000, 1, 1'b0, 1'b0, 1'b1);
        host_access(1'b0, 12'h041, 16'h0000, 1, 1'b0, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
